// File: rtl/fp32_mul_dispatch.sv
// Operand dispatch stage for the fp32 multiplier: queues operand pairs, runs the
// start/done handshake one op at a time with a watchdog, and returns results on valid/ready.
module fp32_mul_dispatch #(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid_i,
   output logic        in_ready_o,
   input  logic [31:0] in_a_i,
   input  logic [31:0] in_b_i,
   output logic        mul_start_o,
   output logic [31:0] mul_a_o,
   output logic [31:0] mul_b_o,
   input  logic        mul_done_i,
   input  logic [31:0] mul_product_i,
   input  logic [3:0]  mul_flags_i,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic [31:0] out_product_o,
   output logic [4:0]  out_flags_o,
   output logic        busy_o,
   output logic [15:0] ops_done_o
);

   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CntW = $clog2(DEPTH + 1);
   localparam int unsigned WdW  = $clog2(TIMEOUT + 2);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

   state_e          state_q;
   logic [31:0]     fifo_a [DEPTH];
   logic [31:0]     fifo_b [DEPTH];
   logic [PtrW-1:0] wr_ptr_q;
   logic [PtrW-1:0] rd_ptr_q;
   logic [CntW-1:0] count_q;
   logic [WdW-1:0]  wd_q;
   logic            mul_start_q;
   logic [31:0]     mul_a_q;
   logic [31:0]     mul_b_q;
   logic            out_valid_q;
   logic [31:0]     out_product_q;
   logic [4:0]      out_flags_q;
   logic [15:0]     ops_done_q;
   logic            push;
   logic            pop;

   // Full is judged on the registered count only, so a same-cycle pop never frees a slot.
   assign in_ready_o = (count_q != CntW'(DEPTH));
   assign push       = in_valid_i && in_ready_o;
   assign pop        = (state_q == StIdle) && (count_q != '0);
   assign busy_o     = (state_q != StIdle) || (count_q != '0);

   assign mul_start_o   = mul_start_q;
   assign mul_a_o       = mul_a_q;
   assign mul_b_o       = mul_b_q;
   assign out_valid_o   = out_valid_q;
   assign out_product_o = out_product_q;
   assign out_flags_o   = out_flags_q;
   assign ops_done_o    = ops_done_q;

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_a[wr_ptr_q] <= in_a_i;
         fifo_b[wr_ptr_q] <= in_b_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         wd_q          <= '0;
         mul_start_q   <= 1'b0;
         mul_a_q       <= '0;
         mul_b_q       <= '0;
         out_valid_q   <= 1'b0;
         out_product_q <= '0;
         out_flags_q   <= '0;
         ops_done_q    <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
         count_q     <= count_q + CntW'(push) - CntW'(pop);
         mul_start_q <= 1'b0;

         case (state_q)
            StIdle: begin
               if (pop) begin
                  mul_a_q     <= fifo_a[rd_ptr_q];
                  mul_b_q     <= fifo_b[rd_ptr_q];
                  mul_start_q <= 1'b1;
                  state_q     <= StIssue;
               end
            end
            StIssue: begin
               wd_q    <= '0;
               state_q <= StWait;
            end
            StWait: begin
               if (mul_done_i) begin
                  out_product_q <= mul_product_i;
                  out_flags_q   <= {1'b0, mul_flags_i};
                  out_valid_q   <= 1'b1;
                  state_q       <= StResp;
               end else if (wd_q == WdW'(TIMEOUT + 1)) begin
                  // Expiry lands the response TIMEOUT+3 cycles after the start pulse.
                  out_product_q <= '0;
                  out_flags_q   <= 5'b10000;
                  out_valid_q   <= 1'b1;
                  state_q       <= StResp;
               end else begin
                  wd_q <= wd_q + WdW'(1);
               end
            end
            StResp: begin
               if (out_ready_i) begin
                  out_valid_q <= 1'b0;
                  ops_done_q  <= ops_done_q + 16'd1;
                  state_q     <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_fp32_mul_dispatch.sv
// Scoreboard bench for fp32_mul_dispatch: stub multiplier plays back hand-computed products,
// a monitor checks each result handshake against the expected queue.
module tb_fp32_mul_dispatch;

   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 15;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] p;
      logic [3:0]  f;
      logic        hang;
   } stub_t;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic        mul_start;
   logic [31:0] mul_a;
   logic [31:0] mul_b;
   logic        mul_done;
   logic [31:0] mul_product;
   logic [3:0]  mul_flags;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_product;
   logic [4:0]  out_flags;
   logic        busy;
   logic [15:0] ops_done;

   logic        stub_done;
   logic [31:0] stub_prod;
   logic [3:0]  stub_flags;
   logic        spur_done;
   logic [31:0] spur_prod;
   logic [3:0]  spur_flags;

   int          tests;
   int          fails;
   int          cyc;
   logic [15:0] exp_ops;
   logic [36:0] exp_q[$];
   stub_t       stub_q[$];
   stub_t       stub_e;
   logic [36:0] mon_e;

   logic [31:0] va [8];
   logic [31:0] vb [8];
   logic [31:0] vp [8];

   assign mul_done    = stub_done | spur_done;
   assign mul_product = spur_done ? spur_prod : stub_prod;
   assign mul_flags   = spur_done ? spur_flags : stub_flags;

   fp32_mul_dispatch #(
      .DEPTH   (DEPTH),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid_i    (in_valid),
      .in_ready_o    (in_ready),
      .in_a_i        (in_a),
      .in_b_i        (in_b),
      .mul_start_o   (mul_start),
      .mul_a_o       (mul_a),
      .mul_b_o       (mul_b),
      .mul_done_i    (mul_done),
      .mul_product_i (mul_product),
      .mul_flags_i   (mul_flags),
      .out_valid_o   (out_valid),
      .out_ready_i   (out_ready),
      .out_product_o (out_product),
      .out_flags_o   (out_flags),
      .busy_o        (busy),
      .ops_done_o    (ops_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_in_ready"},    64'(in_ready),    64'(1));
      check({tag, "_mul_start"},   64'(mul_start),   64'(0));
      check({tag, "_mul_a"},       64'(mul_a),       64'(0));
      check({tag, "_mul_b"},       64'(mul_b),       64'(0));
      check({tag, "_out_valid"},   64'(out_valid),   64'(0));
      check({tag, "_out_product"}, 64'(out_product), 64'(0));
      check({tag, "_out_flags"},   64'(out_flags),   64'(0));
      check({tag, "_busy"},        64'(busy),        64'(0));
      check({tag, "_ops_done"},    64'(ops_done),    64'(0));
   endtask

   // Called at posedge+1; returns at posedge+1 after the pair is accepted.
   task automatic push_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] p,
                          input logic [3:0] f, input logic hang);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      while (!in_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check("push_accept", 64'(in_ready), 64'(1));
      stub_q.push_back('{a: a, b: b, p: p, f: f, hang: hang});
      if (hang) exp_q.push_back({32'h0, 5'b10000});
      else      exp_q.push_back({p, 1'b0, f});
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain(input string tag, input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      check({tag, "_outstanding"}, 64'(exp_q.size()), 64'(0));
      exp_q.delete();
      @(posedge clk); #1;
   endtask

   // Result monitor / scoreboard.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL result_unexpected: got product 0x%0h, expected no result", out_product);
         end else begin
            mon_e = exp_q.pop_front();
            check("result_product", 64'(out_product), 64'(mon_e[36:5]));
            check("result_flags",   64'(out_flags),   64'(mon_e[4:0]));
            exp_ops = exp_ops + 16'd1;
         end
      end
   end

   // Stub multiplier: done two cycles after start, or never for a hang entry.
   initial begin
      stub_done  = 1'b0;
      stub_prod  = '0;
      stub_flags = '0;
      forever begin
         @(negedge clk);
         if (rst_n && mul_start) begin
            if (stub_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL stub_start: got start with a=0x%0h, expected no start", mul_a);
            end else begin
               stub_e = stub_q.pop_front();
               check("mul_a", 64'(mul_a), 64'(stub_e.a));
               check("mul_b", 64'(mul_b), 64'(stub_e.b));
               if (!stub_e.hang) begin
                  @(posedge clk);
                  @(posedge clk); #1;
                  stub_done  = 1'b1;
                  stub_prod  = stub_e.p;
                  stub_flags = stub_e.f;
                  @(posedge clk); #1;
                  stub_done  = 1'b0;
               end else begin
                  for (int i = 0; i < TIMEOUT + 2; i++) begin
                     @(negedge clk);
                     if (!rst_n) break;
                     check("mul_a_hold", 64'(mul_a), 64'(stub_e.a));
                     check("mul_b_hold", 64'(mul_b), 64'(stub_e.b));
                  end
               end
            end
         end
      end
   end

   initial begin
      #200000;
      fails++;
      $display("FAIL global_timeout: got no end of test, expected completion");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      int idx;
      int n;
      int starts;
      int t_start;
      int t_valid;
      logic rdy;

      tests     = 0;
      fails     = 0;
      exp_ops   = '0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      out_ready = 1'b1;
      spur_done = 1'b0;
      spur_prod = '0;
      spur_flags = '0;
      va = '{32'h40000000, 32'h3FC00000, 32'h3F800000, 32'hC0000000,
             32'h3F000000, 32'h41200000, 32'h40400000, 32'h3F000000};
      vb = '{32'h40400000, 32'h40000000, 32'h3F800000, 32'h40800000,
             32'h3F000000, 32'h41200000, 32'h40400000, 32'h40800000};
      vp = '{32'h40C00000, 32'h40400000, 32'h3F800000, 32'hC1000000,
             32'h3E800000, 32'h42C80000, 32'h41100000, 32'h40000000};

      repeat (3) @(posedge clk);
      #1;
      check_reset_vals("in_reset");
      rst_n = 1'b1;
      @(posedge clk); #1;
      check_reset_vals("after_reset");

      // Single op: 2.0 * 3.0 with exact cycle timing.
      in_valid = 1'b1;
      in_a     = va[0];
      in_b     = vb[0];
      stub_q.push_back('{a: va[0], b: vb[0], p: vp[0], f: 4'h0, hang: 1'b0});
      exp_q.push_back({vp[0], 5'b00000});
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         check($sformatf("single_start_c%0d", c), 64'(mul_start), 64'(c == 2));
         check($sformatf("single_valid_c%0d", c), 64'(out_valid), 64'(c == 5));
      end
      @(posedge clk); #1;
      drain("single", 20);
      check("single_ops_done", 64'(ops_done), 64'(16'd1));

      // Flag passthrough: NaN, then infinity+overflow.
      push_op(va[0], vb[0], 32'h00000000, 4'b1000, 1'b0);
      push_op(va[5], vb[5], 32'h7F800000, 4'b0110, 1'b0);
      drain("flags", 40);
      check("flags_ops_done", 64'(ops_done), 64'(exp_ops));

      // Backpressure: consumer stalled, 8 pairs offered, 5 fit.
      out_ready = 1'b0;
      idx = 0;
      for (int c = 0; c < 20; c++) begin
         in_valid = (idx < 8);
         in_a     = va[idx % 8];
         in_b     = vb[idx % 8];
         rdy      = in_ready;
         @(posedge clk); #1;
         if (rdy && idx < 8) begin
            stub_q.push_back('{a: va[idx], b: vb[idx], p: vp[idx], f: 4'h0, hang: 1'b0});
            exp_q.push_back({vp[idx], 5'b00000});
            idx++;
         end
      end
      in_valid = 1'b0;
      check("bp_accepted", 64'(idx), 64'(5));
      check("bp_in_ready", 64'(in_ready), 64'(0));
      check("bp_valid_held", 64'(out_valid), 64'(1));
      check("bp_product_held", 64'(out_product), 64'(vp[0]));
      // A stray done while the result is stalled must be ignored.
      spur_done  = 1'b1;
      spur_prod  = 32'hDEADBEEF;
      spur_flags = 4'hF;
      @(posedge clk); #1;
      spur_done  = 1'b0;
      @(posedge clk); #1;
      check("bp_product_after_stray", 64'(out_product), 64'(vp[0]));
      check("bp_flags_after_stray", 64'(out_flags), 64'(0));
      out_ready = 1'b1;
      drain("bp", 100);
      check("bp_in_ready_back", 64'(in_ready), 64'(1));
      check("bp_ops_done", 64'(ops_done), 64'(exp_ops));

      // Watchdog: hung multiplier, then a normal op behind it.
      push_op(va[1], vb[1], 32'h0, 4'h0, 1'b1);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!mul_start && n < 20);
      check("wd_start_seen", 64'(mul_start), 64'(1));
      t_start = cyc;
      @(posedge clk); #1;
      push_op(va[2], vb[2], vp[2], 4'h0, 1'b0);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid && n < 40);
      t_valid = cyc;
      check("wd_latency", 64'(t_valid - t_start), 64'(TIMEOUT + 3));
      @(posedge clk); #1;
      drain("wd", 60);
      check("wd_ops_done", 64'(ops_done), 64'(exp_ops));

      // Reset while in WAIT with 3 pairs queued.
      push_op(va[3], vb[3], 32'h0, 4'h0, 1'b1);
      push_op(va[4], vb[4], vp[4], 4'h0, 1'b0);
      push_op(va[5], vb[5], vp[5], 4'h0, 1'b0);
      push_op(va[6], vb[6], vp[6], 4'h0, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("rst_pre_busy", 64'(busy), 64'(1));
      check("rst_pre_full", 64'(in_ready), 64'(1));
      rst_n = 1'b0;
      #1;
      check_reset_vals("rst_async");
      exp_q.delete();
      stub_q.delete();
      exp_ops = '0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      starts = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (mul_start) starts++;
      end
      check("rst_no_start", 64'(starts), 64'(0));
      @(posedge clk); #1;
      check_reset_vals("rst_after");

      // ops_done wrap and FIFO pointer wrap over 3*DEPTH ops.
      force dut.ops_done_q = 16'hFFFE;
      @(posedge clk); #1;
      release dut.ops_done_q;
      exp_ops = 16'hFFFE;
      check("wrap_preload", 64'(ops_done), 64'(16'hFFFE));
      push_op(va[7], vb[7], vp[7], 4'h0, 1'b0);
      drain("wrap1", 20);
      check("wrap_ffff", 64'(ops_done), 64'(16'hFFFF));
      push_op(va[0], vb[0], vp[0], 4'h0, 1'b0);
      drain("wrap2", 20);
      check("wrap_zero", 64'(ops_done), 64'(16'h0000));
      for (int i = 0; i < 3 * DEPTH; i++) begin
         push_op(va[i % 8], vb[i % 8], vp[i % 8], 4'(i), 1'b0);
      end
      drain("ptr_wrap", 200);
      check("ptr_wrap_ops_done", 64'(ops_done), 64'(3 * DEPTH));
      check("end_busy", 64'(busy), 64'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
